// File: rtl/prog_ctr_seq.sv
`default_nettype none
// ============================================================================
// Module   : prog_ctr_seq
// Brief    : Program counter sequencer (IDLE/RUN/DONE) with branches, halt
//            and a saturating run-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module prog_ctr_seq #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CountEn,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Halt,
    input  logic             BranchAbs,
    input  logic             BranchRel,
    input  logic             Taken,
    input  logic [PC_W-1:0]  Target,
    input  logic [OFF_W-1:0] Offset,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state, w_state_nxt;
    logic [PC_W-1:0]  r_pc, w_pc_nxt;
    logic             r_done, w_done_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [PC_W-1:0]  w_off_ext;
    logic [CNT_W-1:0] w_cnt_inc;

    // Sign-extend the relative offset; the add below drops the carry.
    assign w_off_ext = PC_W'($signed(Offset));
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_done_nxt  = r_done;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_pc_nxt   = StartAddr;
                w_done_nxt = 1'b0;
                if (CountEn) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                // The halt cycle and the abort cycle both count as RUN cycles.
                w_cnt_nxt = w_cnt_inc;
                if (!CountEn) begin
                    w_state_nxt = S_IDLE;
                    w_pc_nxt    = StartAddr;
                    w_done_nxt  = 1'b0;
                end else if (Halt) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else if (BranchAbs && Taken) begin
                    w_pc_nxt = Target;
                end else if (BranchRel && Taken) begin
                    w_pc_nxt = r_pc + w_off_ext;
                end else begin
                    w_pc_nxt = r_pc + PC_W'(1);
                end
            end
            S_DONE: begin
                if (!CountEn) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b0;
                    w_pc_nxt    = StartAddr;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ProgCtr  = r_pc;
    assign Done     = r_done;
    assign CycleCnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prog_ctr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_ctr_seq
// Brief    : Scoreboard bench for prog_ctr_seq: directed plan then random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_ctr_seq;

    localparam int PC_W  = 10;
    localparam int OFF_W = 8;
    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset, CountEn, Halt, BranchAbs, BranchRel, Taken;
    logic [PC_W-1:0]  StartAddr, Target;
    logic [OFF_W-1:0] Offset;
    logic [PC_W-1:0]  ProgCtr;
    logic             Done;
    logic [CNT_W-1:0] CycleCnt;

    prog_ctr_seq #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .CountEn(CountEn), .StartAddr(StartAddr),
        .Halt(Halt), .BranchAbs(BranchAbs), .BranchRel(BranchRel),
        .Taken(Taken), .Target(Target), .Offset(Offset),
        .ProgCtr(ProgCtr), .Done(Done), .CycleCnt(CycleCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int pc;
        int done;
        int cnt;
        bit cnt_known;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: phase 0 = waiting, 1 = running, 2 = finished.
    int m_phase = 0, m_pc = 0, m_done = 0, m_cnt = 0;
    bit m_cnt_known = 1'b1;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    task automatic model_edge();
        int off;
        exp_t e;
        if (Reset) begin
            m_phase = 0; m_pc = 0; m_done = 0; m_cnt = 0; m_cnt_known = 1'b1;
        end else if (m_phase == 0) begin
            m_pc = int'(StartAddr);
            m_done = 0;
            if (CountEn) begin
                m_phase = 1; m_cnt = 0; m_cnt_known = 1'b1;
            end
        end else if (m_phase == 1) begin
            m_cnt = (m_cnt < CNT_TOP) ? m_cnt + 1 : CNT_TOP;
            off = int'(Offset);
            if (off >= (1 << (OFF_W - 1))) off = off - (1 << OFF_W);
            if (!CountEn) begin
                m_phase = 0; m_pc = int'(StartAddr); m_done = 0;
                m_cnt_known = 1'b0;
            end else if (Halt) begin
                m_phase = 2; m_done = 1;
            end else if (BranchAbs && Taken) begin
                m_pc = int'(Target);
            end else if (BranchRel && Taken) begin
                m_pc = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end else begin
            if (!CountEn) begin
                m_phase = 0; m_done = 0; m_pc = int'(StartAddr);
            end
        end
        e.pc = m_pc; e.done = m_done; e.cnt = m_cnt; e.cnt_known = m_cnt_known;
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            model_edge();
            #1;
        end
    endtask

    task automatic clr_dec();
        Halt = 1'b0; BranchAbs = 1'b0; BranchRel = 1'b0; Taken = 1'b0;
        Target = '0; Offset = '0;
    endtask

    task automatic restart(input logic [PC_W-1:0] sa);
        CountEn = 1'b0;
        cyc(1);
        StartAddr = sa;
        CountEn   = 1'b1;
        cyc(1);
    endtask

    // Monitor: outputs are registered, so one result per clock is checked.
    always @(negedge Clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (int'(ProgCtr) != e.pc) begin
                n_bad++;
                $display("FAIL pc: got %0h expected %0h at %0t", ProgCtr, e.pc, $time);
            end
            n_cmp++;
            if (int'(Done) != e.done) begin
                n_bad++;
                $display("FAIL done: got %0d expected %0d at %0t", Done, e.done, $time);
            end
            if (e.cnt_known) begin
                n_cmp++;
                if (int'(CycleCnt) != e.cnt) begin
                    n_bad++;
                    $display("FAIL cnt: got %0d expected %0d at %0t", CycleCnt, e.cnt, $time);
                end
            end
        end
    end

    initial begin
        Reset = 1'b1; CountEn = 1'b0; StartAddr = 10'h040;
        clr_dec();
        cyc(2);
        // Reset and start
        Reset = 1'b0; CountEn = 1'b1;
        cyc(5);
        // Branches
        restart(10'h050);
        BranchAbs = 1'b1; Taken = 1'b1; Target = 10'h123; cyc(1);
        BranchAbs = 1'b0; BranchRel = 1'b1; Offset = 8'hF0; cyc(1);
        Taken = 1'b0; cyc(1);
        BranchAbs = 1'b1; Taken = 1'b1; Target = 10'h200; cyc(1);
        clr_dec();
        // Wrap-around
        restart(10'h3FE);
        cyc(3);
        BranchRel = 1'b1; Taken = 1'b1; Offset = 8'hFE; cyc(1);
        clr_dec();
        // Halt, decoder activity in DONE, leave DONE, restart
        restart(10'h010);
        cyc(3);
        Halt = 1'b1; cyc(1);
        BranchAbs = 1'b1; BranchRel = 1'b1; Taken = 1'b1;
        Target = 10'h155; Offset = 8'h07; StartAddr = 10'h0AA; cyc(3);
        clr_dec();
        CountEn = 1'b0; cyc(1);
        CountEn = 1'b1; cyc(3);
        // Abort while Halt is asserted
        restart(10'h020);
        cyc(2);
        Halt = 1'b1; CountEn = 1'b0; cyc(1);
        Halt = 1'b0; CountEn = 1'b1; cyc(2);
        // Reset mid-run, then saturation
        restart(10'h0A5);
        cyc(2);
        Reset = 1'b1; cyc(1);
        Reset = 1'b0; cyc(20);
        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            Reset     = ($urandom_range(0, 99) < 2);
            CountEn   = ($urandom_range(0, 99) < 90);
            Halt      = ($urandom_range(0, 99) < 4);
            BranchAbs = ($urandom_range(0, 99) < 15);
            BranchRel = ($urandom_range(0, 99) < 20);
            Taken     = $urandom_range(0, 1);
            StartAddr = PC_W'($urandom);
            Target    = PC_W'($urandom);
            Offset    = OFF_W'($urandom);
            cyc(1);
        end
        clr_dec();
        Reset = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge Clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
